// File: rtl/rf_debug_pkg.sv
// Shared types for the register-file debug arbiter: FSM state encoding
// and the default pipeline drain depth (E, M, W).
package rf_debug_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        ACCESS  = 2'd2,
        RESPOND = 2'd3
    } dbg_state_e;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/drain_counter.sv
// Down-counter that times the pipeline drain before the debug path owns
// the register file write port.
module drain_counter #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DRAIN_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_VAL;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Arbitrates the decode-stage register file write/test-read ports between
// pipeline writeback and a debug requester, freezing the pipeline around accesses.
module regfile_debug_arbiter
    import rf_debug_pkg::*;
#(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5,
    parameter int DRAIN_CYCLES           = DRAIN_CYCLES_DEF
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              RegWriteW,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
    input  logic [DATA_WIDTH-1:0]             ResultW,
    input  logic                              dbg_req_valid,
    output logic                              dbg_req_ready,
    input  logic                              dbg_req_write,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0]             dbg_req_wdata,
    output logic                              dbg_rsp_valid,
    input  logic                              dbg_rsp_ready,
    output logic [DATA_WIDTH-1:0]             dbg_rsp_rdata,
    input  logic [DATA_WIDTH-1:0]             testRegData,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] testRegAddress,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] rf_A3,
    output logic [DATA_WIDTH-1:0]             rf_WD3,
    output logic                              rf_WE3,
    output logic                              StallF,
    output logic                              StallD,
    output logic                              FlushE,
    output logic                              dbg_halted
);

    dbg_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  drain_load, drain_dec, drain_zero;
    logic                  addr_nz, dbg_we, stall;

    assign drain_load = (state_q == RUN) && dbg_req_valid;
    assign drain_dec  = (state_q == DRAIN);

    drain_counter #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_drain (
        .clk    (clk),
        .rst    (reset),
        .load_i (drain_load),
        .dec_i  (drain_dec),
        .zero_o (drain_zero)
    );

    assign addr_nz = (dbg_req_addr != '0);
    // x0 is hardwired: never pulse the write enable for it.
    assign dbg_we  = (state_q == ACCESS) && dbg_req_valid && dbg_req_write && addr_nz;

    always_comb begin
        state_d       = state_q;
        rdata_d       = rdata_q;
        dbg_req_ready = 1'b0;
        case (state_q)
            RUN:   if (dbg_req_valid) state_d = DRAIN;
            DRAIN: if (drain_zero)    state_d = ACCESS;
            ACCESS: begin
                dbg_req_ready = dbg_req_valid;
                if (dbg_req_valid) begin
                    state_d = RESPOND;
                    // Read sees the pre-write value: the write commits at this same edge.
                    if (!dbg_req_write) rdata_d = testRegData;
                    else if (addr_nz)   rdata_d = dbg_req_wdata;
                    else                rdata_d = '0;
                end else begin
                    state_d = RUN;
                end
            end
            RESPOND: if (dbg_rsp_ready) state_d = dbg_req_valid ? ACCESS : RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign stall          = (state_q != RUN);
    assign StallF         = stall;
    assign StallD         = stall;
    assign FlushE         = stall;
    assign dbg_halted     = (state_q == ACCESS) || (state_q == RESPOND);
    assign dbg_rsp_valid  = (state_q == RESPOND);
    assign dbg_rsp_rdata  = rdata_q;
    assign testRegAddress = dbg_req_addr;

    always_comb begin
        rf_A3  = RdW;
        rf_WD3 = ResultW;
        rf_WE3 = RegWriteW;
        if (dbg_halted) begin
            rf_A3  = dbg_req_addr;
            rf_WD3 = dbg_req_wdata;
            rf_WE3 = dbg_we;
        end
    end

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Directed bench for regfile_debug_arbiter with a behavioural register file
// attached to the write port and the test-read port.
module tb_regfile_debug_arbiter;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
    logic [4:0]  dbg_req_addr;
    logic [31:0] dbg_req_wdata;
    logic        dbg_rsp_valid, dbg_rsp_ready;
    logic [31:0] dbg_rsp_rdata;
    logic [31:0] testRegData;
    logic [4:0]  testRegAddress, rf_A3;
    logic [31:0] rf_WD3;
    logic        rf_WE3, StallF, StallD, FlushE, dbg_halted;

    int vectors    = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int wr_snap;
    bit rf_clr;
    logic [31:0] regs [32];

    regfile_debug_arbiter #(
        .DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5), .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk), .reset(reset),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
        .dbg_req_wdata(dbg_req_wdata),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_rdata(dbg_rsp_rdata),
        .testRegData(testRegData), .testRegAddress(testRegAddress),
        .rf_A3(rf_A3), .rf_WD3(rf_WD3), .rf_WE3(rf_WE3),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .dbg_halted(dbg_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: x0 reads zero, writes land on the rising edge.
    always @(posedge clk or posedge rf_clr) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_WE3) begin
            wr_cnt <= wr_cnt + 1;
            if (rf_A3 != 5'd0) regs[rf_A3] <= rf_WD3;
        end
    end
    assign testRegData = regs[testRegAddress];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = '0;
        dbg_req_wdata = '0; dbg_rsp_ready = 1'b0;
        rf_clr = 1'b1; #1 rf_clr = 1'b0; #1;

        // Reset values
        check("rst_ready",  dbg_req_ready, 0);
        check("rst_rspv",   dbg_rsp_valid, 0);
        check("rst_rdata",  dbg_rsp_rdata, 0);
        check("rst_halted", dbg_halted, 0);
        check("rst_stall",  {StallF, StallD, FlushE}, 0);
        go; reset = 1'b0;

        // Read after pipeline write
        RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h1234; #1;
        check("run_pass_we", rf_WE3, 1);
        check("run_pass_a3", rf_A3, 5);
        check("run_pass_wd", rf_WD3, 32'h1234);
        go;
        RegWriteW = 1'b0;
        dbg_req_valid = 1'b1; dbg_req_write = 1'b0; dbg_req_addr = 5'd5; #1;   // cycle 0
        check("rd_c0_stall", StallF, 0);
        go; #1;                                                               // cycle 1
        check("rd_c1_stall", {StallF, StallD, FlushE}, 3'b111);
        check("rd_c1_ready", dbg_req_ready, 0);
        check("rd_c1_halt",  dbg_halted, 0);
        go; #1; check("rd_c2_stall", StallF, 1);
        go; #1; check("rd_c3_ready", dbg_req_ready, 0);
        go; #1;                                                               // cycle 4
        check("rd_c4_ready", dbg_req_ready, 1);
        check("rd_c4_halt",  dbg_halted, 1);
        check("rd_c4_taddr", testRegAddress, 5);
        check("rd_c4_we",    rf_WE3, 0);
        go; dbg_req_valid = 1'b0; dbg_rsp_ready = 1'b1; #1;                   // cycle 5
        check("rd_c5_rspv",  dbg_rsp_valid, 1);
        check("rd_c5_rdata", dbg_rsp_rdata, 32'h1234);
        check("rd_c5_stall", StallF, 1);
        go; #1;
        check("rd_c6_stall", StallF, 0);
        check("rd_c6_rspv",  dbg_rsp_valid, 0);

        // Write during drain, pipeline targets the same register
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd7;
        dbg_req_wdata = 32'hDEADBEEF; #1;
        go; RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h11111111; #1;          // cycle 1
        check("wr_drain_we", rf_WE3, 1);
        check("wr_drain_wd", rf_WD3, 32'h11111111);
        go; RegWriteW = 1'b0; #1;
        check("wr_pipe_landed", regs[7], 32'h11111111);
        go; go; #1;                                                           // cycle 4
        check("wr_c4_ready", dbg_req_ready, 1);
        check("wr_c4_we",    rf_WE3, 1);
        check("wr_c4_a3",    rf_A3, 7);
        check("wr_c4_wd",    rf_WD3, 32'hDEADBEEF);
        go; dbg_req_write = 1'b0; #1;                                         // cycle 5, next req: read x7
        check("wr_c5_rdata", dbg_rsp_rdata, 32'hDEADBEEF);
        check("wr_c5_we",    rf_WE3, 0);
        check("wr_c5_reg",   regs[7], 32'hDEADBEEF);
        go; #1;                                                               // ACCESS again, no drain
        check("wr_rd_ready", dbg_req_ready, 1);
        go; dbg_req_valid = 1'b0; #1;
        check("wr_rd_rdata", dbg_rsp_rdata, 32'hDEADBEEF);
        go; #1;
        check("wr_rd_release", StallF, 0);

        // Write to x0
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd0;
        dbg_req_wdata = 32'hFFFFFFFF; wr_snap = wr_cnt; #1;
        go; go; go; go; #1;
        check("x0_ready", dbg_req_ready, 1);
        check("x0_we",    rf_WE3, 0);
        go; dbg_req_write = 1'b0; #1;
        check("x0_rdata", dbg_rsp_rdata, 0);
        go; #1; check("x0_rd_ready", dbg_req_ready, 1);
        go; dbg_req_valid = 1'b0; #1;
        check("x0_rd_rdata", dbg_rsp_rdata, 0);
        check("x0_no_write", wr_cnt, wr_snap);
        go;

        // Back-to-back with backpressure on the second response
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd9;
        dbg_req_wdata = 32'hA5A5A5A5; #1;
        go; go; go; go; #1;
        check("b2b_ready1", dbg_req_ready, 1);
        go; dbg_req_write = 1'b0; #1;
        check("b2b_rdata1", dbg_rsp_rdata, 32'hA5A5A5A5);
        go; dbg_rsp_ready = 1'b0; #1;
        check("b2b_ready2", dbg_req_ready, 1);
        go; dbg_req_addr = 5'd5; #1;
        check("b2b_rspv2",   dbg_rsp_valid, 1);
        check("b2b_rdata2",  dbg_rsp_rdata, 32'hA5A5A5A5);
        check("b2b_noready", dbg_req_ready, 0);
        go; #1; check("b2b_hold1", dbg_rsp_rdata, 32'hA5A5A5A5);
        go; #1; check("b2b_hold2", dbg_rsp_rdata, 32'hA5A5A5A5);
        go; dbg_rsp_ready = 1'b1; #1;
        check("b2b_rspv_hs", dbg_rsp_valid, 1);
        go; #1;
        check("b2b_ready3", dbg_req_ready, 1);
        check("b2b_taddr3", testRegAddress, 5);
        go; dbg_req_valid = 1'b0; #1;
        check("b2b_rdata3", dbg_rsp_rdata, 32'h1234);
        check("b2b_stall3", StallF, 1);
        go; #1;
        check("b2b_release", StallF, 0);
        check("b2b_halted",  dbg_halted, 0);

        // Reset asserted in RESPOND
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd12;
        dbg_req_wdata = 32'h55AA; dbg_rsp_ready = 1'b0; #1;
        go; go; go; go; go; dbg_req_valid = 1'b0; #1;
        check("rr_rspv",   dbg_rsp_valid, 1);
        check("rr_commit", regs[12], 32'h55AA);
        wr_snap = wr_cnt;
        reset = 1'b1; #1;
        check("rr_async_rspv",  dbg_rsp_valid, 0);
        check("rr_async_rdata", dbg_rsp_rdata, 0);
        check("rr_async_halt",  dbg_halted, 0);
        check("rr_async_stall", {StallF, StallD, FlushE}, 0);
        check("rr_async_we",    rf_WE3, 0);
        go; reset = 1'b0; go; #1;
        check("rr_run_stall", StallF, 0);
        check("rr_no_write",  wr_cnt, wr_snap);

        // Valid withdrawn during DRAIN
        dbg_req_valid = 1'b1; dbg_req_write = 1'b1; dbg_req_addr = 5'd13;
        dbg_req_wdata = 32'h77; dbg_rsp_ready = 1'b1; wr_snap = wr_cnt; #1;
        go; dbg_req_valid = 1'b0; #1;
        check("wd_drain_stall", StallF, 1);
        go; go; go; #1;
        check("wd_access_halt",  dbg_halted, 1);
        check("wd_access_ready", dbg_req_ready, 0);
        check("wd_access_we",    rf_WE3, 0);
        go; #1;
        check("wd_run_rspv",  dbg_rsp_valid, 0);
        check("wd_run_stall", StallF, 0);
        check("wd_reg13",     regs[13], 0);
        check("wd_no_write",  wr_cnt, wr_snap);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
